// File: rtl/aes_block_fifo.sv
`default_nettype none
// ============================================================================
// Module   : aes_block_fifo
// Brief    : Circular block FIFO between the receive shifter and the AES core,
//            with occupancy count, almost-full backpressure, flush and sticky
//            overflow/underflow flags.
// Revision : 1.0 - initial release
// ============================================================================
module aes_block_fifo #(
    parameter int WIDTH    = 128,
    parameter int DEPTH    = 8,
    parameter int AF_LEVEL = DEPTH - 2
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       clear,
    input  logic [WIDTH-1:0]           din,
    input  logic                       wr_en,
    input  logic                       rd_en,
    output logic [WIDTH-1:0]           dout,
    output logic                       dout_valid,
    output logic                       empty,
    output logic                       full,
    output logic                       almost_full,
    output logic [$clog2(DEPTH+1)-1:0] count,
    output logic                       overflow,
    output logic                       underflow
);

    localparam int c_AW = $clog2(DEPTH);
    localparam int c_CW = $clog2(DEPTH + 1);
    localparam logic [c_CW-1:0] c_DEPTH_CNT = c_CW'(DEPTH);
    localparam logic [c_CW-1:0] c_AF_CNT    = c_CW'(AF_LEVEL);
    localparam logic [c_CW-1:0] c_ONE       = c_CW'(1);

    logic [WIDTH-1:0] r_mem [DEPTH];
    logic [c_AW-1:0]  r_wp;
    logic [c_AW-1:0]  r_rp;
    logic [c_CW-1:0]  r_count;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_overflow;
    logic             r_underflow;

    logic w_empty;
    logic w_full;
    logic w_rd_ok;
    logic w_wr_ok;

    assign w_empty = (r_count == '0);
    assign w_full  = (r_count == c_DEPTH_CNT);

    // Read qualifies on the pre-cycle count only; a write into a full FIFO
    // is still accepted when a read frees a slot in the same cycle.
    assign w_rd_ok = rd_en && !w_empty && !clear;
    assign w_wr_ok = wr_en && (!w_full || w_rd_ok) && !clear;

    // Storage is not reset; contents are meaningless until written.
    always_ff @(posedge clk) begin
        if (w_wr_ok) begin
            r_mem[r_wp] <= din;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else if (clear) begin
            r_wp         <= '0;
            r_rp         <= '0;
            r_count      <= '0;
            r_dout_valid <= 1'b0;
            r_overflow   <= 1'b0;
            r_underflow  <= 1'b0;
        end else begin
            r_dout_valid <= w_rd_ok;
            if (w_wr_ok) begin
                r_wp <= r_wp + 1'b1;
            end
            if (w_rd_ok) begin
                r_dout <= r_mem[r_rp];
                r_rp   <= r_rp + 1'b1;
            end
            if (w_wr_ok && !w_rd_ok) begin
                r_count <= r_count + c_ONE;
            end else if (w_rd_ok && !w_wr_ok) begin
                r_count <= r_count - c_ONE;
            end
            if (wr_en && !w_wr_ok) begin
                r_overflow <= 1'b1;
            end
            if (rd_en && w_empty) begin
                r_underflow <= 1'b1;
            end
        end
    end

    assign dout        = r_dout;
    assign dout_valid  = r_dout_valid;
    assign empty       = w_empty;
    assign full        = w_full;
    assign almost_full = (r_count >= c_AF_CNT);
    assign count       = r_count;
    assign overflow    = r_overflow;
    assign underflow   = r_underflow;

endmodule
`default_nettype wire

// File: tb/tb_aes_block_fifo.sv
`default_nettype none
// ============================================================================
// Module   : tb_aes_block_fifo
// Brief    : Directed self-checking bench for aes_block_fifo (WIDTH=128, DEPTH=8).
// Revision : 1.0 - initial release
// ============================================================================
module tb_aes_block_fifo;

    localparam int WIDTH = 128;
    localparam int DEPTH = 8;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic             clear = 1'b0;
    logic [WIDTH-1:0] din = '0;
    logic             wr_en = 1'b0;
    logic             rd_en = 1'b0;
    logic [WIDTH-1:0] dout;
    logic             dout_valid;
    logic             empty;
    logic             full;
    logic             almost_full;
    logic [3:0]       count;
    logic             overflow;
    logic             underflow;

    int errors = 0;
    int checks = 0;

    aes_block_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(DEPTH - 2)) dut (
        .clk         (clk),
        .reset       (reset),
        .clear       (clear),
        .din         (din),
        .wr_en       (wr_en),
        .rd_en       (rd_en),
        .dout        (dout),
        .dout_valid  (dout_valid),
        .empty       (empty),
        .full        (full),
        .almost_full (almost_full),
        .count       (count),
        .overflow    (overflow),
        .underflow   (underflow)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, got timeout, expected completion");
        $fatal(1, "watchdog");
    end

    // Advance one edge and settle 1 time unit after it.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        wr_en = 1'b0; rd_en = 1'b0; clear = 1'b0;
    endtask

    task automatic do_clear();
        idle(); clear = 1'b1; tick(); clear = 1'b0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        #3;
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || full !== 1'b0 || almost_full !== 1'b0
            || dout !== '0 || dout_valid !== 1'b0 || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL reset_state: count=%0d empty=%b full=%b af=%b dv=%b ovf=%b unf=%b, expected 0 1 0 0 0 0 0",
                     count, empty, full, almost_full, dout_valid, overflow, underflow);
        end
        @(posedge clk); #1; reset = 1'b1;
    endtask

    task automatic test_fill();
        for (int i = 1; i <= DEPTH; i++) begin
            wr_en = 1'b1; din = WIDTH'(i); tick();
            checks++;
            if (count !== 4'(i) || almost_full !== (i >= 6)) begin
                errors++;
                $display("FAIL fill_count[%0d]: count=%0d af=%b, expected %0d %b", i, count, almost_full, i, (i >= 6));
            end
        end
        checks++;
        if (full !== 1'b1 || overflow !== 1'b0) begin
            errors++;
            $display("FAIL fill_full: full=%b ovf=%b, expected 1 0", full, overflow);
        end
        din = 128'hFF; tick(); idle();
        checks++;
        if (overflow !== 1'b1 || count !== 4'd8) begin
            errors++;
            $display("FAIL fill_overflow: ovf=%b count=%0d, expected 1 8", overflow, count);
        end
    endtask

    task automatic test_drain();
        for (int i = 1; i <= DEPTH; i++) begin
            rd_en = 1'b1; tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== WIDTH'(i)) begin
                errors++;
                $display("FAIL drain_data[%0d]: dv=%b dout=%0h, expected 1 %0h", i, dout_valid, dout, i);
            end
        end
        checks++;
        if (empty !== 1'b1 || count !== 4'd0) begin
            errors++;
            $display("FAIL drain_empty: empty=%b count=%0d, expected 1 0", empty, count);
        end
        tick(); idle();
        checks++;
        if (underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== WIDTH'(8)) begin
            errors++;
            $display("FAIL drain_underflow: unf=%b dv=%b dout=%0h, expected 1 0 8", underflow, dout_valid, dout);
        end
        do_clear();
        checks++;
        if (overflow !== 1'b0 || underflow !== 1'b0 || dout !== WIDTH'(8)) begin
            errors++;
            $display("FAIL clear_flags: ovf=%b unf=%b dout=%0h, expected 0 0 8", overflow, underflow, dout);
        end
    endtask

    task automatic test_wrap();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = WIDTH'(32'h20 + i); tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1; tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== WIDTH'(32'h20 + i)) begin
                errors++;
                $display("FAIL wrap_first[%0d]: dv=%b dout=%0h, expected 1 %0h", i, dout_valid, dout, 32'h20 + i);
            end
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = WIDTH'(32'h10 + i); tick();
        end
        idle();
        for (int i = 0; i < 8; i++) begin
            rd_en = 1'b1; tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== WIDTH'(32'h10 + i)) begin
                errors++;
                $display("FAIL wrap_data[%0d]: dv=%b dout=%0h, expected 1 %0h", i, dout_valid, dout, 32'h10 + i);
            end
        end
        idle();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL wrap_end: count=%0d empty=%b unf=%b, expected 0 1 0", count, empty, underflow);
        end
    endtask

    task automatic test_simultaneous();
        for (int i = 0; i < 8; i++) begin
            wr_en = 1'b1; din = WIDTH'(32'h30 + i); tick();
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 128'hAA; tick(); idle();
        checks++;
        if (count !== 4'd8 || overflow !== 1'b0 || dout_valid !== 1'b1 || dout !== WIDTH'(32'h30)) begin
            errors++;
            $display("FAIL sim_full: count=%0d ovf=%b dv=%b dout=%0h, expected 8 0 1 30", count, overflow, dout_valid, dout);
        end
        for (int i = 1; i <= 8; i++) begin
            rd_en = 1'b1; tick();
            checks++;
            if (dout !== ((i == 8) ? WIDTH'(32'hAA) : WIDTH'(32'h30 + i))) begin
                errors++;
                $display("FAIL sim_drain[%0d]: dout=%0h, expected %0h", i, dout, (i == 8) ? 32'hAA : 32'h30 + i);
            end
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 128'hBB; tick(); idle();
        checks++;
        if (count !== 4'd1 || underflow !== 1'b1 || dout_valid !== 1'b0 || dout !== WIDTH'(32'hAA)) begin
            errors++;
            $display("FAIL sim_empty: count=%0d unf=%b dv=%b dout=%0h, expected 1 1 0 aa", count, underflow, dout_valid, dout);
        end
        wr_en = 1'b1; rd_en = 1'b1; din = 128'hCC; tick(); idle();
        checks++;
        if (count !== 4'd1 || dout_valid !== 1'b1 || dout !== WIDTH'(32'hBB)) begin
            errors++;
            $display("FAIL sim_one: count=%0d dv=%b dout=%0h, expected 1 1 bb", count, dout_valid, dout);
        end
        rd_en = 1'b1; tick(); idle();
        checks++;
        if (dout !== WIDTH'(32'hCC) || count !== 4'd0) begin
            errors++;
            $display("FAIL sim_one_tail: dout=%0h count=%0d, expected cc 0", dout, count);
        end
        do_clear();
    endtask

    task automatic test_flush();
        for (int i = 0; i < 9; i++) begin
            wr_en = 1'b1; din = (i == 8) ? WIDTH'(32'hFF) : WIDTH'(32'h40 + i); tick();
        end
        idle();
        for (int i = 0; i < 5; i++) begin
            rd_en = 1'b1; tick();
        end
        idle();
        checks++;
        if (count !== 4'd3 || overflow !== 1'b1 || dout !== WIDTH'(32'h44)) begin
            errors++;
            $display("FAIL flush_setup: count=%0d ovf=%b dout=%0h, expected 3 1 44", count, overflow, dout);
        end
        clear = 1'b1; wr_en = 1'b1; din = 128'h99; tick(); idle();
        checks++;
        if (count !== 4'd0 || empty !== 1'b1 || overflow !== 1'b0 || dout_valid !== 1'b0) begin
            errors++;
            $display("FAIL flush_state: count=%0d empty=%b ovf=%b dv=%b, expected 0 1 0 0", count, empty, overflow, dout_valid);
        end
        wr_en = 1'b1; din = 128'h55; tick(); idle();
        rd_en = 1'b1; tick(); idle();
        checks++;
        if (dout_valid !== 1'b1 || dout !== WIDTH'(32'h55) || count !== 4'd0) begin
            errors++;
            $display("FAIL flush_after: dv=%b dout=%0h count=%0d, expected 1 55 0", dout_valid, dout, count);
        end
    endtask

    task automatic test_async_reset();
        for (int i = 0; i < 5; i++) begin
            wr_en = 1'b1; din = WIDTH'(32'h70 + i); tick();
        end
        wr_en = 1'b0; rd_en = 1'b1; tick(); idle();
        checks++;
        if (count !== 4'd4 || dout !== WIDTH'(32'h70) || dout_valid !== 1'b1) begin
            errors++;
            $display("FAIL areset_setup: count=%0d dout=%0h dv=%b, expected 4 70 1", count, dout, dout_valid);
        end
        #1; reset = 1'b0; #1;
        checks++;
        if (count !== 4'd0 || dout !== '0 || dout_valid !== 1'b0 || empty !== 1'b1
            || overflow !== 1'b0 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_immediate: count=%0d dout=%0h dv=%b empty=%b, expected 0 0 0 1", count, dout, dout_valid, empty);
        end
        tick(); reset = 1'b1;
        wr_en = 1'b1; din = 128'h61; tick();
        din = 128'h62; tick(); idle();
        for (int i = 0; i < 2; i++) begin
            rd_en = 1'b1; tick();
            checks++;
            if (dout_valid !== 1'b1 || dout !== WIDTH'(32'h61 + i)) begin
                errors++;
                $display("FAIL areset_after[%0d]: dv=%b dout=%0h, expected 1 %0h", i, dout_valid, dout, 32'h61 + i);
            end
        end
        idle(); tick();
        checks++;
        if (empty !== 1'b1 || underflow !== 1'b0) begin
            errors++;
            $display("FAIL areset_end: empty=%b unf=%b, expected 1 0", empty, underflow);
        end
    endtask

    initial begin
        test_reset();
        test_fill();
        test_drain();
        test_wrap();
        test_simultaneous();
        test_flush();
        test_async_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
`default_nettype wire
